// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg
// Shared AHB-Lite types for the slave-to-master response mux.
//   htrans_t   : AHB transfer type encoding
//   ds_state_t : default-slave response FSM states
//   is_transfer: true for the transfer types that start a data phase
// ---------------------------------------------------------------------------
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_t;

  // BUSY and IDLE carry no data phase; only NONSEQ/SEQ need a response.
  function automatic logic is_transfer(input htrans_t t);
    return (t == NONSEQ) || (t == SEQ);
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// ---------------------------------------------------------------------------
// ahb_default_slave
// Two-cycle AHB ERROR response generator that owns the data phase of any
// transfer whose address decoded to no slave or to several slaves.
// Ports:
//   hclk, hresetn : bus clock, synchronous active-low reset
//   dec_err       : decode error accepted this cycle (already qualified by HREADY)
//   ds_busy       : default slave owns the current data phase
//   ds_hready     : HREADY while ds_busy (low in first ERROR cycle)
//   ds_hresp      : HRESP while ds_busy (always ERROR)
//   err_entry     : pulses on the cycle before a fresh first ERROR cycle
// ---------------------------------------------------------------------------
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic hclk,
  input  logic hresetn,
  input  logic dec_err,
  output logic ds_busy,
  output logic ds_hready,
  output logic ds_hresp,
  output logic err_entry
);

  ds_state_t state_q, state_d;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    ds_busy   = 1'b0;
    ds_hready = 1'b1;
    ds_hresp  = 1'b0;
    unique case (state_q)
      DS_IDLE: begin
        if (dec_err) state_d = DS_ERR1;
      end
      DS_ERR1: begin
        // First ERROR cycle must stall so the master can cancel the next transfer.
        ds_busy   = 1'b1;
        ds_hready = 1'b0;
        ds_hresp  = 1'b1;
        state_d   = DS_ERR2;
      end
      DS_ERR2: begin
        ds_busy   = 1'b1;
        ds_hready = 1'b1;
        ds_hresp  = 1'b1;
        state_d   = dec_err ? DS_ERR1 : DS_IDLE;
      end
      default: state_d = DS_IDLE;
    endcase
  end

  // DS_ERR1 is never re-entered from itself, so this marks each new error exactly once.
  assign err_entry = (state_d == DS_ERR1) && (state_q != DS_ERR1);

  always_ff @(posedge hclk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of process ordering.
    if (!hresetn) state_q <= DS_IDLE;
    else          state_q <= state_d;
  end

endmodule

// File: rtl/ahb_s2m_resp_mux.sv
// ---------------------------------------------------------------------------
// ahb_s2m_resp_mux
// Registered-select AHB-Lite slave-to-master response mux. The address-phase
// slave select is latched when HREADY is high and steers the selected slave's
// data-phase response to the master through a one-hot AND-OR mux. Decode
// errors are answered by an integrated default slave. Also keeps a saturating
// decode-error counter and a sticky wait-state timeout flag.
// Ports:
//   hclk, hresetn         : bus clock, synchronous active-low reset
//   hsel[NSLV]            : address-phase one-hot slave select
//   htrans[2]             : address-phase transfer type
//   hready_i/hresp_i/hexokay_i[NSLV], hrdata_i[NSLV][DATA_WIDTH] : slave responses
//   hready_o/hresp_o/hexokay_o/hrdata_o : muxed response to master (and HREADY to slaves)
//   err_clr               : clears dec_err_cnt and timeout_flag
//   dec_err_cnt[ERRCNT_W] : saturating count of default-slave ERROR responses
//   timeout_flag          : sticky, hready_o low for TIMEOUT consecutive cycles
// ---------------------------------------------------------------------------
module ahb_s2m_resp_mux
  import ahb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NSLV       = 5,
  parameter int ERRCNT_W   = 8,
  parameter int TIMEOUT    = 256
) (
  input  logic                             hclk,
  input  logic                             hresetn,
  input  logic [NSLV-1:0]                  hsel,
  input  logic [1:0]                       htrans,
  input  logic [NSLV-1:0]                  hready_i,
  input  logic [NSLV-1:0]                  hresp_i,
  input  logic [NSLV-1:0]                  hexokay_i,
  input  logic [NSLV-1:0][DATA_WIDTH-1:0]  hrdata_i,
  output logic                             hready_o,
  output logic                             hresp_o,
  output logic                             hexokay_o,
  output logic [DATA_WIDTH-1:0]            hrdata_o,
  input  logic                             err_clr,
  output logic [ERRCNT_W-1:0]              dec_err_cnt,
  output logic                             timeout_flag
);

  // Wait counter only needs to reach TIMEOUT; it saturates there.
  localparam int              TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [NSLV-1:0]       dsel_q, dsel_d;
  logic                  dact_q, dact_d;
  logic [TO_W-1:0]       wait_cnt_q, wait_cnt_d;
  logic [ERRCNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic                  flag_q, flag_d;

  logic                  addr_xfer;
  logic                  dec_err;
  logic                  mux_active;
  logic                  ds_busy, ds_hready, ds_hresp, err_entry;
  logic                  mux_ready, mux_resp, mux_exokay;
  logic [DATA_WIDTH-1:0] mux_rdata;
  logic                  timeout_set;

  // ---------------- address-phase select register ----------------
  assign addr_xfer = is_transfer(htrans_t'(htrans));
  assign dec_err   = hready_o && addr_xfer && !$onehot(hsel);

  always_comb begin
    dsel_d = dsel_q;
    dact_d = dact_q;
    if (hready_o) begin
      dsel_d = hsel;
      dact_d = addr_xfer;
    end
  end

  // ---------------- default slave ----------------
  ahb_default_slave u_default_slave (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .dec_err   (dec_err),
    .ds_busy   (ds_busy),
    .ds_hready (ds_hready),
    .ds_hresp  (ds_hresp),
    .err_entry (err_entry)
  );

  // ---------------- one-hot AND-OR mux ----------------
  // Non-selected lanes are ANDed with zero, so X on idle slaves never reaches
  // the master; the whole mux is also gated off outside a one-hot data phase.
  assign mux_active = dact_q && $onehot(dsel_q);

  always_comb begin
    mux_rdata  = '0;
    mux_ready  = |(dsel_q & hready_i);
    mux_resp   = |(dsel_q & hresp_i);
    mux_exokay = |(dsel_q & hexokay_i);
    for (int i = 0; i < NSLV; i++) begin
      mux_rdata = mux_rdata | ({DATA_WIDTH{dsel_q[i]}} & hrdata_i[i]);
    end
  end

  always_comb begin
    hready_o  = 1'b1;
    hresp_o   = 1'b0;
    hexokay_o = 1'b0;
    hrdata_o  = '0;
    if (ds_busy) begin
      hready_o = ds_hready;
      hresp_o  = ds_hresp;
    end else if (mux_active) begin
      hready_o  = mux_ready;
      hresp_o   = mux_resp;
      hexokay_o = mux_exokay;
      hrdata_o  = mux_rdata;
    end
  end

  // ---------------- counters ----------------
  assign timeout_set = (TIMEOUT != 0) && !hready_o && (wait_cnt_q == TO_LAST);

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (hready_o)                  wait_cnt_d = '0;
    else if (wait_cnt_q != TO_MAX) wait_cnt_d = wait_cnt_q + TO_W'(1);

    // err_clr wins over a same-cycle increment or set.
    err_cnt_d = err_cnt_q;
    flag_d    = flag_q | timeout_set;
    if (err_clr) begin
      err_cnt_d = '0;
      flag_d    = 1'b0;
    end else if (err_entry && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERRCNT_W'(1);
    end
  end

  always_ff @(posedge hclk) begin
    // NOTE: all state here is plain flops (no memory arrays), so every register
    // is reset to bring the outputs to an idle OKAY response.
    if (!hresetn) begin
      dsel_q     <= '0;
      dact_q     <= 1'b0;
      wait_cnt_q <= '0;
      err_cnt_q  <= '0;
      flag_q     <= 1'b0;
    end else begin
      dsel_q     <= dsel_d;
      dact_q     <= dact_d;
      wait_cnt_q <= wait_cnt_d;
      err_cnt_q  <= err_cnt_d;
      flag_q     <= flag_d;
    end
  end

  assign dec_err_cnt  = err_cnt_q;
  assign timeout_flag = flag_q;

endmodule

// File: tb/tb_ahb_s2m_resp_mux.sv
// ---------------------------------------------------------------------------
// tb_ahb_s2m_resp_mux
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a transaction-level model.
// ---------------------------------------------------------------------------
module tb_ahb_s2m_resp_mux;

  localparam int DW   = 32;
  localparam int NS   = 5;
  localparam int EW   = 8;
  localparam int TOUT = 4;

  logic                  hclk = 1'b0;
  logic                  hresetn;
  logic [NS-1:0]         hsel;
  logic [1:0]            htrans;
  logic [NS-1:0]         hready_i, hresp_i, hexokay_i;
  logic [NS-1:0][DW-1:0] hrdata_i;
  logic                  hready_o, hresp_o, hexokay_o;
  logic [DW-1:0]         hrdata_o;
  logic                  err_clr;
  logic [EW-1:0]         dec_err_cnt;
  logic                  timeout_flag;

  int total = 0;
  int bad   = 0;

  always #5 hclk = ~hclk;

  ahb_s2m_resp_mux #(
    .DATA_WIDTH (DW),
    .NSLV       (NS),
    .ERRCNT_W   (EW),
    .TIMEOUT    (TOUT)
  ) dut (
    .hclk         (hclk),
    .hresetn      (hresetn),
    .hsel         (hsel),
    .htrans       (htrans),
    .hready_i     (hready_i),
    .hresp_i      (hresp_i),
    .hexokay_i    (hexokay_i),
    .hrdata_i     (hrdata_i),
    .hready_o     (hready_o),
    .hresp_o      (hresp_o),
    .hexokay_o    (hexokay_o),
    .hrdata_o     (hrdata_o),
    .err_clr      (err_clr),
    .dec_err_cnt  (dec_err_cnt),
    .timeout_flag (timeout_flag)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The model tracks the owner of the current data phase: a slave index, or
  // a number of remaining ERROR cycles from the default slave, or nothing.
  bit model_init = 1'b0;
  int m_slave    = -1;   // slave owning the data phase, -1 = none
  int m_err_left = 0;    // ERROR response cycles still to deliver (2 or 1)
  int m_run      = 0;    // consecutive cycles with HREADY low
  bit m_flag     = 1'b0;
  int m_cnt      = 0;

  logic          e_ready, e_resp, e_exokay;
  logic [DW-1:0] e_rdata;
  int            ones, idx;
  bit            xfer;

  always @(negedge hclk) begin
    e_ready = 1'b1; e_resp = 1'b0; e_exokay = 1'b0; e_rdata = '0;
    if (m_err_left == 2) begin
      e_ready = 1'b0; e_resp = 1'b1;
    end else if (m_err_left == 1) begin
      e_resp = 1'b1;
    end else if (m_slave >= 0) begin
      e_ready  = hready_i[m_slave];
      e_resp   = hresp_i[m_slave];
      e_exokay = hexokay_i[m_slave];
      e_rdata  = hrdata_i[m_slave];
    end

    if (model_init) begin
      check("hready_o",     32'(hready_o),     32'(e_ready));
      check("hresp_o",      32'(hresp_o),      32'(e_resp));
      check("hexokay_o",    32'(hexokay_o),    32'(e_exokay));
      check("hrdata_o",     hrdata_o,          e_rdata);
      check("dec_err_cnt",  32'(dec_err_cnt),  32'(m_cnt));
      check("timeout_flag", 32'(timeout_flag), 32'(m_flag));
    end

    if (!hresetn) begin
      m_slave = -1; m_err_left = 0; m_run = 0; m_flag = 1'b0; m_cnt = 0;
      model_init = 1'b1;
    end else begin
      if (e_ready) begin
        m_run = 0;
        xfer  = htrans[1];
        ones  = 0; idx = -1;
        for (int i = 0; i < NS; i++) if (hsel[i]) begin ones++; idx = i; end
        m_err_left = 0;
        m_slave    = -1;
        if (xfer && ones == 1) m_slave = idx;
        else if (xfer) begin
          m_err_left = 2;
          if (m_cnt < 255) m_cnt++;
        end
      end else begin
        m_run++;
        if (m_run == TOUT) m_flag = 1'b1;
        if (m_err_left == 2) m_err_left = 1;
      end
      if (err_clr) begin
        m_flag = 1'b0; m_cnt = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive(input logic [NS-1:0] sel, input logic [1:0] tr);
    hsel   = sel;
    htrans = tr;
  endtask

  initial begin
    int r;
    hresetn = 1'b0; err_clr = 1'b0;
    hsel = '0; htrans = 2'b00;
    hready_i = '1; hresp_i = '0; hexokay_i = '0; hrdata_i = '0;

    // Reset
    repeat (2) @(posedge hclk);
    #1;
    check("rst_hready", 32'(hready_o), 32'd1);
    check("rst_hresp",  32'(hresp_o),  32'd0);
    check("rst_hrdata", hrdata_o,      32'd0);
    check("rst_cnt",    32'(dec_err_cnt), 32'd0);
    hresetn = 1'b1;
    tick();

    // Single read from slave 2
    hrdata_i[2] = 32'hA5A5_0002;
    hrdata_i[0] = 32'h0000_0B00;
    drive(5'b00100, 2'b10);
    tick();
    drive(5'b00000, 2'b00);
    #1;
    check("rd_hrdata", hrdata_o, 32'hA5A5_0002);
    check("rd_hready", 32'(hready_o), 32'd1);
    tick();

    // Slave 2 waits 3 cycles; new select for slave 0 held off
    drive(5'b00100, 2'b10);
    tick();
    drive(5'b00001, 2'b10);
    hready_i[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("wait_hready", 32'(hready_o), 32'd0);
      tick();
    end
    hready_i[2] = 1'b1;
    #1;
    check("wait_done_hready", 32'(hready_o), 32'd1);
    check("wait_done_hrdata", hrdata_o, 32'hA5A5_0002);
    tick();
    drive(5'b00000, 2'b00);
    #1;
    check("next_slave0", hrdata_o, 32'h0000_0B00);
    check("no_timeout", 32'(timeout_flag), 32'd0);
    tick();

    // Decode error with hsel=0, then back-to-back multi-hot error
    drive(5'b00000, 2'b10);
    tick();
    drive(5'b00000, 2'b00);
    #1;
    check("err1_hready", 32'(hready_o), 32'd0);
    check("err1_hresp",  32'(hresp_o),  32'd1);
    tick();
    drive(5'b00011, 2'b10);
    #1;
    check("err2_hready", 32'(hready_o), 32'd1);
    check("err2_hresp",  32'(hresp_o),  32'd1);
    check("err_cnt1",    32'(dec_err_cnt), 32'd1);
    tick();
    drive(5'b00000, 2'b00);
    #1;
    check("b2b_err1_hready", 32'(hready_o), 32'd0);
    check("b2b_err1_hresp",  32'(hresp_o),  32'd1);
    check("err_cnt2",        32'(dec_err_cnt), 32'd2);
    tick();
    #1;
    check("b2b_err2_hready", 32'(hready_o), 32'd1);
    check("b2b_err2_hresp",  32'(hresp_o),  32'd1);
    tick();

    // Timeout after 4 wait cycles, then clear
    drive(5'b00010, 2'b10);
    tick();
    drive(5'b00000, 2'b00);
    hready_i[1] = 1'b0;
    repeat (4) tick();
    hready_i[1] = 1'b1;
    #1;
    check("timeout_set", 32'(timeout_flag), 32'd1);
    repeat (3) tick();
    check("timeout_sticky", 32'(timeout_flag), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    #1;
    check("clr_flag", 32'(timeout_flag), 32'd0);
    check("clr_cnt",  32'(dec_err_cnt),  32'd0);

    // Saturation of the decode-error counter
    for (int k = 0; k < 256; k++) begin
      drive(5'b00000, 2'b10);
      tick();
      drive(5'b00000, 2'b00);
      tick();
    end
    check("sat_cnt", 32'(dec_err_cnt), 32'hFF);
    drive(5'b00000, 2'b11);
    tick();
    drive(5'b00000, 2'b00);
    #1;
    check("sat_err1_hready", 32'(hready_o), 32'd0);
    check("sat_hold", 32'(dec_err_cnt), 32'hFF);
    repeat (2) tick();
    // IDLE with hsel=0 is OKAY with no wait and no count
    #1;
    check("idle_hready", 32'(hready_o), 32'd1);
    check("idle_hresp",  32'(hresp_o),  32'd0);
    tick();
    check("idle_no_count", 32'(dec_err_cnt), 32'hFF);

    // Randomized traffic, checked every cycle by the model
    for (int c = 0; c < 3000; c++) begin
      r = int'($urandom_range(99));
      if (r < 60)      hsel = NS'(1) << $urandom_range(NS - 1);
      else if (r < 75) hsel = '0;
      else             hsel = NS'($urandom);
      htrans = 2'($urandom);
      for (int i = 0; i < NS; i++) begin
        hready_i[i] = ($urandom_range(99) < 70);
        hrdata_i[i] = $urandom;
      end
      hresp_i   = NS'($urandom);
      hexokay_i = NS'($urandom);
      err_clr   = ($urandom_range(99) < 3);
      hresetn   = ($urandom_range(999) >= 5);
      tick();
    end
    hresetn = 1'b1; err_clr = 1'b0;
    drive('0, 2'b00);
    hready_i = '1;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
